// File: rtl/data_cache_controller_pkg.sv
// Shared types and constants for the L1 data cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_cache_controller_pkg;

   localparam int WORD_BITS       = 32;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int BLOCK_BITS      = WORD_BITS * WORDS_PER_BLOCK;
   localparam int OFFSET_BITS     = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2,
      ST_UPDATE    = 2'd3
   } cache_state_t;

   // memReadEn[2:0] load width codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // memWriteEn[1:0] store size codes
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Byte lanes touched by a store. Halfwords use addr[1] only and words
   // ignore the low address bits, so misaligned stores are silently aligned.
   function automatic logic [3:0] store_byte_en(input logic [1:0] size,
                                                input logic [1:0] byte_sel);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << byte_sel;
         SZ_H:    be = byte_sel[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/data_cache_controller_load_store_align.sv
// Lane extraction with sign/zero extension for loads; byte-lane merge for stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: byte_sel = addr[1:0]; load_funct3 / store_size = width codes;
//        cur_word = cached word; store_data = CPU store data;
//        load_data = extended load result; merged_word = cur_word with store lanes replaced.
module data_cache_controller_load_store_align
   import data_cache_controller_pkg::*;
(
   input  logic [1:0]  byte_sel,
   input  logic [2:0]  load_funct3,
   input  logic [1:0]  store_size,
   input  logic [31:0] cur_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] st_rep;
   logic [3:0]  be;

   always_comb begin
      lane_b = cur_word[{byte_sel, 3'b000} +: 8];
      lane_h = byte_sel[1] ? cur_word[31:16] : cur_word[15:0];

      load_data = '0;
      case (load_funct3)
         F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         F3_LW:   load_data = cur_word;
         F3_LBU:  load_data = {24'd0, lane_b};
         F3_LHU:  load_data = {16'd0, lane_h};
         default: load_data = '0;
      endcase

      // Replicate the low bits across the word so every enabled lane sees its byte.
      st_rep = store_data;
      case (store_size)
         SZ_B:    st_rep = {4{store_data[7:0]}};
         SZ_H:    st_rep = {2{store_data[15:0]}};
         default: st_rep = store_data;
      endcase

      be          = store_byte_en(store_size, byte_sel);
      merged_word = cur_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged_word[8*i +: 8] = st_rep[8*i +: 8];
      end
   end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back write-allocate L1 data cache (16 B blocks).
// Latency: hits complete in the request cycle; misses stall through WRITEBACK/FETCH/UPDATE.
// Backpressure: DATA_CACHE_BUSY_WAIT stalls the CPU; mem_busywait holds the FSM in a transfer state.
// Ports: CPU side memReadEn/memWriteEn/DATA_CACHE_ADDR/DATA_CACHE_DATA in, READ_DATA/BUSY_WAIT out;
//        memory side mem_read/mem_write/mem_address/mem_writedata out, mem_readdata/mem_busywait in.
module data_cache_controller
   import data_cache_controller_pkg::*;
#(
   parameter int INDEX_BITS = 3
)(
   input  logic         CLK,
   input  logic         RESET,
   input  logic [3:0]   memReadEn,
   input  logic [2:0]   memWriteEn,
   input  logic [31:0]  DATA_CACHE_ADDR,
   input  logic [31:0]  DATA_CACHE_DATA,
   output logic [31:0]  DATA_CACHE_READ_DATA,
   output logic         DATA_CACHE_BUSY_WAIT,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_address,
   output logic [127:0] mem_writedata,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;
   localparam int SETS     = 1 << INDEX_BITS;

   cache_state_t          state;
   logic [SETS-1:0]       valid;
   logic [SETS-1:0]       dirty;
   logic [TAG_BITS-1:0]   tag_arr  [SETS];
   logic [BLOCK_BITS-1:0] data_arr [SETS];

   // Missing block captured in IDLE so the fill completes even if the CPU withdraws.
   logic [TAG_BITS-1:0]   miss_tag;
   logic [INDEX_BITS-1:0] miss_idx;

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_idx;
   logic [1:0]            req_word;
   logic                  req;
   logic                  hit;
   logic                  store_hit;
   logic                  load_hit;
   logic [31:0]           cur_word;
   logic [31:0]           load_data;
   logic [31:0]           merged_word;

   assign req_tag  = DATA_CACHE_ADDR[31 -: TAG_BITS];
   assign req_idx  = DATA_CACHE_ADDR[OFFSET_BITS +: INDEX_BITS];
   assign req_word = DATA_CACHE_ADDR[3:2];

   assign req       = memReadEn[3] | memWriteEn[2];
   assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag) && (state == ST_IDLE);
   // A simultaneous load+store request is treated purely as a store.
   assign store_hit = memWriteEn[2] & hit;
   assign load_hit  = memReadEn[3] & ~memWriteEn[2] & hit;
   assign cur_word  = data_arr[req_idx][{req_word, 5'd0} +: WORD_BITS];

   assign DATA_CACHE_BUSY_WAIT = req & ~hit;
   assign DATA_CACHE_READ_DATA = load_hit ? load_data : '0;

   data_cache_controller_load_store_align u_align (
      .byte_sel    (DATA_CACHE_ADDR[1:0]),
      .load_funct3 (memReadEn[2:0]),
      .store_size  (memWriteEn[1:0]),
      .cur_word    (cur_word),
      .store_data  (DATA_CACHE_DATA),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Miss FSM; memory-side outputs are registered on the transitions so they
   // are valid exactly while in WRITEBACK/FETCH and zero elsewhere.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= ST_IDLE;
         valid         <= '0;
         dirty         <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req && !hit) begin
                  miss_tag <= req_tag;
                  miss_idx <= req_idx;
                  if (dirty[req_idx]) begin
                     state         <= ST_WRITEBACK;
                     mem_write     <= 1'b1;
                     mem_address   <= {tag_arr[req_idx], req_idx};
                     mem_writedata <= data_arr[req_idx];
                  end else begin
                     state       <= ST_FETCH;
                     mem_read    <= 1'b1;
                     mem_address <= DATA_CACHE_ADDR[31:4];
                  end
               end else if (store_hit) begin
                  dirty[req_idx] <= 1'b1;
               end
            end
            ST_WRITEBACK: begin
               if (!mem_busywait) begin
                  state         <= ST_FETCH;
                  mem_write     <= 1'b0;
                  mem_writedata <= '0;
                  mem_read      <= 1'b1;
                  mem_address   <= {miss_tag, miss_idx};
               end
            end
            ST_FETCH: begin
               if (!mem_busywait) begin
                  state       <= ST_UPDATE;
                  mem_read    <= 1'b0;
                  mem_address <= '0;
               end
            end
            ST_UPDATE: begin
               state           <= ST_IDLE;
               valid[miss_idx] <= 1'b1;
               dirty[miss_idx] <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Tag/data arrays carry no reset; they are qualified by valid.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (state == ST_UPDATE) begin
            data_arr[miss_idx] <= mem_readdata;
            tag_arr[miss_idx]  <= miss_tag;
         end else if (store_hit) begin
            data_arr[req_idx][{req_word, 5'd0} +: WORD_BITS] <= merged_word;
         end
      end
   end

endmodule

// File: tb/tb_data_cache_controller.sv
module tb_data_cache_controller;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [3:0]   memReadEn;
   logic [2:0]   memWriteEn;
   logic [31:0]  DATA_CACHE_ADDR;
   logic [31:0]  DATA_CACHE_DATA;
   logic [31:0]  DATA_CACHE_READ_DATA;
   logic         DATA_CACHE_BUSY_WAIT;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata = '0;
   logic         mem_busywait = 1'b0;

   data_cache_controller dut (
      .CLK(CLK), .RESET(RESET), .memReadEn(memReadEn), .memWriteEn(memWriteEn),
      .DATA_CACHE_ADDR(DATA_CACHE_ADDR), .DATA_CACHE_DATA(DATA_CACHE_DATA),
      .DATA_CACHE_READ_DATA(DATA_CACHE_READ_DATA), .DATA_CACHE_BUSY_WAIT(DATA_CACHE_BUSY_WAIT),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // ---------------- main memory (bench side) ----------------
   logic [127:0] mem_blk [logic [27:0]];   // physical main memory
   logic [127:0] ref_blk [logic [27:0]];   // architectural memory image seen by the CPU
   logic [27:0]  wb_addr_q [$];
   logic [127:0] wb_data_q [$];
   logic [27:0]  rd_q [$];
   int           mem_lat = 0;
   int           lat_cnt = 0;

   function automatic logic [127:0] init_blk(input logic [27:0] a);
      logic [127:0] b;
      for (int i = 0; i < 4; i++)
         b[32*i +: 32] = {4'h0, a} * 32'h9E3779B1 + 32'(i) * 32'h1F2E3D4C;
      return b;
   endfunction

   function automatic logic [127:0] mem_get(input logic [27:0] a);
      return mem_blk.exists(a) ? mem_blk[a] : init_blk(a);
   endfunction

   function automatic logic [127:0] ref_get(input logic [27:0] a);
      return ref_blk.exists(a) ? ref_blk[a] : init_blk(a);
   endfunction

   // Memory responder: holds busywait for mem_lat cycles, then completes.
   always @(negedge CLK) begin
      if (mem_read || mem_write) begin
         if (lat_cnt < mem_lat) begin
            mem_busywait = 1'b1;
            lat_cnt++;
         end else begin
            mem_busywait = 1'b0;
            lat_cnt = 0;
            if (mem_write) begin
               mem_blk[mem_address] = mem_writedata;
               wb_addr_q.push_back(mem_address);
               wb_data_q.push_back(mem_writedata);
            end else begin
               mem_readdata = mem_get(mem_address);
               rd_q.push_back(mem_address);
            end
         end
      end else begin
         mem_busywait = 1'b0;
         lat_cnt = 0;
      end
   end

   // ---------------- reference model: which block each set holds ----------------
   bit          res_valid [8];
   bit          res_dirty [8];
   logic [24:0] res_tag   [8];

   task automatic model_access(input bit st, input logic [2:0] code, input logic [31:0] addr,
                               input logic [31:0] data, output bit miss, output bit wb,
                               output logic [27:0] wa, output logic [127:0] wd, output logic [31:0] rd);
      int          s  = int'(addr[6:4]);
      int          wi = int'(addr[3:2]);
      logic [127:0] b;
      logic [31:0]  w, mask;
      logic [7:0]   by;
      logic [15:0]  hw;
      miss = !(res_valid[s] && res_tag[s] == addr[31:7]);
      wb   = miss && res_valid[s] && res_dirty[s];
      wa   = {res_tag[s], addr[6:4]};
      wd   = ref_get(wa);
      if (miss) begin
         res_valid[s] = 1'b1;
         res_tag[s]   = addr[31:7];
         res_dirty[s] = 1'b0;
      end
      b  = ref_get(addr[31:4]);
      w  = b[32*wi +: 32];
      by = 8'(w >> (8 * addr[1:0]));
      hw = 16'(w >> (16 * addr[1]));
      rd = '0;
      if (st) begin
         case (code[1:0])
            2'b00: begin mask = 32'hFF << (8 * addr[1:0]);
                         w = (w & ~mask) | ((data & 32'hFF) << (8 * addr[1:0])); end
            2'b01: begin mask = 32'hFFFF << (16 * addr[1]);
                         w = (w & ~mask) | ((data & 32'hFFFF) << (16 * addr[1])); end
            2'b10: w = data;
            default: ;
         endcase
         b[32*wi +: 32] = w;
         ref_blk[addr[31:4]] = b;
         res_dirty[s] = 1'b1;
      end else begin
         case (code)
            3'b000: rd = {{24{by[7]}}, by};
            3'b001: rd = {{16{hw[15]}}, hw};
            3'b010: rd = w;
            3'b100: rd = {24'd0, by};
            3'b101: rd = {16'd0, hw};
            default: rd = '0;
         endcase
      end
   endtask

   // Reset drops the cache contents: dirty data that never reached memory is lost.
   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         if (res_valid[s] && res_dirty[s])
            ref_blk[{res_tag[s], 3'(s)}] = mem_get({res_tag[s], 3'(s)});
         res_valid[s] = 1'b0;
         res_dirty[s] = 1'b0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] mre, input logic [2:0] mwe,
                        input logic [31:0] addr, input logic [31:0] data);
      memReadEn = mre; memWriteEn = mwe; DATA_CACHE_ADDR = addr; DATA_CACHE_DATA = data;
   endtask

   // Present a request until BUSY_WAIT drops, then hold it across one posedge.
   task automatic do_access(input logic [3:0] mre, input logic [2:0] mwe, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rdata, output int stalls);
      bit done = 0;
      @(negedge CLK);
      drive(mre, mwe, addr, data);
      stalls = 0;
      rdata  = '0;
      for (int c = 0; c < 400 && !done; c++) begin
         #1;
         if (!DATA_CACHE_BUSY_WAIT) begin
            rdata = DATA_CACHE_READ_DATA;
            done  = 1;
         end else begin
            stalls++;
            @(negedge CLK);
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout: addr %h still stalled after 400 cycles", addr);
      end
      @(posedge CLK);
      #1 drive(4'b0, 3'b0, 32'h0, 32'h0);
   endtask

   task automatic acc(input logic [3:0] mre, input logic [2:0] mwe, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata, output int stalls);
      bit miss, wb;
      logic [27:0]  wa;
      logic [127:0] wd;
      logic [31:0]  erd;
      model_access(mwe[2], mwe[2] ? {1'b0, mwe[1:0]} : mre[2:0], addr, data, miss, wb, wa, wd, erd);
      wb_addr_q.delete(); wb_data_q.delete(); rd_q.delete();
      do_access(mre, mwe, addr, data, rdata, stalls);
      chk($sformatf("stalled@%h", addr), 128'(stalls > 0), 128'(miss));
      chk($sformatf("rdata@%h", addr), rdata, erd);
      chk($sformatf("wb_count@%h", addr), wb_addr_q.size(), 128'(wb));
      if (wb && wb_addr_q.size() > 0) begin
         chk($sformatf("wb_addr@%h", addr), wb_addr_q[0], wa);
         chk($sformatf("wb_data@%h", addr), wb_data_q[0], wd);
      end
      if (miss) begin
         chk($sformatf("rd_count@%h", addr), rd_q.size(), 1);
         if (rd_q.size() > 0) chk($sformatf("rd_addr@%h", addr), rd_q[0], addr[31:4]);
      end
   endtask

   typedef struct {
      logic [3:0]  mre;
      logic [2:0]  mwe;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0]  rd;
      logic [127:0] blk;
      int           st;
      int           rd_cyc, bad;
      bit           seen;
      bit           miss, wb;
      logic [27:0]  wa;
      logic [127:0] wd;
      logic [31:0]  erd;

      RESET = 1'b1;
      drive(4'b0, 3'b0, 32'h0, 32'h0);
      mem_blk[28'h4] = {32'h44332211, 32'h88776655, 32'h0BADF00D, 32'hAABBCCDD};
      ref_blk[28'h4] = mem_blk[28'h4];

      // block 0x4 after fill: w3=44332211 w2=88776655 w1=0BADF00D w0=AABBCCDD
      vecs[0]  = '{4'b1000, 3'b000, 32'h43, 32'h0,        32'hFFFFFFAA}; // LB
      vecs[1]  = '{4'b1100, 3'b000, 32'h43, 32'h0,        32'h000000AA}; // LBU
      vecs[2]  = '{4'b1001, 3'b000, 32'h42, 32'h0,        32'hFFFFAABB}; // LH
      vecs[3]  = '{4'b1101, 3'b000, 32'h41, 32'h0,        32'h0000CCDD}; // LHU, addr[0] ignored
      vecs[4]  = '{4'b0000, 3'b101, 32'h42, 32'h00001234, 32'h00000000}; // SH
      vecs[5]  = '{4'b1010, 3'b000, 32'h40, 32'h0,        32'h1234CCDD}; // LW
      vecs[6]  = '{4'b1010, 3'b000, 32'h43, 32'h0,        32'h1234CCDD}; // LW, low bits ignored
      vecs[7]  = '{4'b0000, 3'b100, 32'h45, 32'hFFFFFF77, 32'h00000000}; // SB
      vecs[8]  = '{4'b1010, 3'b000, 32'h44, 32'h0,        32'h0BAD770D};
      vecs[9]  = '{4'b1000, 3'b000, 32'h47, 32'h0,        32'h0000000B};
      vecs[10] = '{4'b1001, 3'b000, 32'h4E, 32'h0,        32'h00004433};
      vecs[11] = '{4'b1000, 3'b000, 32'h4B, 32'h0,        32'hFFFFFF88};
      vecs[12] = '{4'b1101, 3'b000, 32'h4A, 32'h0,        32'h00008877};
      vecs[13] = '{4'b1010, 3'b110, 32'h4C, 32'hCAFEF00D, 32'h00000000}; // load+store -> store
      vecs[14] = '{4'b1010, 3'b000, 32'h4C, 32'h0,        32'hCAFEF00D};
      vecs[15] = '{4'b1001, 3'b000, 32'h4D, 32'h0,        32'hFFFFF00D};

      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK); #1;
      chk("reset_busy", DATA_CACHE_BUSY_WAIT, 0);
      chk("reset_mem_read", mem_read, 0);
      chk("reset_mem_write", mem_write, 0);
      chk("reset_read_data", DATA_CACHE_READ_DATA, 0);

      // First fill: clean miss on block 0x4.
      acc(4'b1010, 3'b000, 32'h40, 32'h0, rd, st);
      chk("fill_rdata", rd, 32'hAABBCCDD);
      chk("fill_stalled", 128'(st > 0), 1);
      chk("fill_addr", (rd_q.size() == 1) ? rd_q[0] : 28'hFFFFFFF, 28'h4);

      for (int i = 0; i < 16; i++) begin
         acc(vecs[i].mre, vecs[i].mwe, vecs[i].addr, vecs[i].data, rd, st);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_nostall", i), st, 0);
      end

      // Dirty eviction: same index 4, new tag.
      acc(4'b1010, 3'b000, 32'hC0, 32'h0, rd, st);
      chk("evict_wb_n", wb_addr_q.size(), 1);
      if (wb_addr_q.size() > 0) begin
         chk("evict_wb_addr", wb_addr_q[0], 28'h4);
         chk("evict_wb_data", wb_data_q[0],
             {32'hCAFEF00D, 32'h88776655, 32'h0BAD770D, 32'h1234CCDD});
      end
      chk("evict_rd_addr", (rd_q.size() == 1) ? rd_q[0] : 28'hFFFFFFF, 28'hC);
      blk = init_blk(28'hC);
      chk("evict_rdata", rd, blk[31:0]);

      // Slow memory: busywait held 10 cycles in FETCH.
      mem_lat = 10;
      model_access(1'b0, 3'b010, 32'h100, 32'h0, miss, wb, wa, wd, erd);
      @(negedge CLK);
      drive(4'b1010, 3'b000, 32'h100, 32'h0);
      #1;
      rd_cyc = 0; bad = 0; seen = 0;
      for (int c = 0; c < 100; c++) begin
         if (mem_read) begin
            rd_cyc++;
            seen = 1;
            if (!DATA_CACHE_BUSY_WAIT) bad++;
         end else if (seen) begin
            break;
         end
         @(negedge CLK); #1;
      end
      chk("slow_fetch_cycles", rd_cyc, 11);
      chk("slow_busy_dropped", bad, 0);
      chk("slow_update_busy", DATA_CACHE_BUSY_WAIT, 1);
      @(negedge CLK); #1;
      chk("slow_hit_busy", DATA_CACHE_BUSY_WAIT, 0);
      chk("slow_hit_rdata", DATA_CACHE_READ_DATA, erd);
      @(posedge CLK);
      #1 drive(4'b0, 3'b0, 32'h0, 32'h0);

      // Reset while a fetch is in flight.
      @(negedge CLK);
      drive(4'b1010, 3'b000, 32'h200, 32'h0);
      repeat (3) @(negedge CLK);
      #1 chk("abort_in_fetch", mem_read, 1);
      @(negedge CLK);
      RESET = 1'b1;
      drive(4'b0, 3'b0, 32'h0, 32'h0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      chk("abort_mem_read", mem_read, 0);
      chk("abort_idle_busy", DATA_CACHE_BUSY_WAIT, 0);
      model_reset();
      mem_lat = 0;
      acc(4'b1010, 3'b000, 32'h100, 32'h0, rd, st);
      chk("abort_prior_line_misses", 128'(st > 0), 1);

      // Request withdrawn mid-miss: line is still filled.
      mem_lat = 3;
      model_access(1'b0, 3'b010, 32'h300, 32'h0, miss, wb, wa, wd, erd);
      @(negedge CLK);
      drive(4'b1010, 3'b000, 32'h300, 32'h0);
      #1 chk("withdraw_busy", DATA_CACHE_BUSY_WAIT, 1);
      @(negedge CLK);
      drive(4'b0, 3'b0, 32'h0, 32'h0);
      repeat (10) @(negedge CLK);
      acc(4'b1010, 3'b000, 32'h300, 32'h0, rd, st);
      chk("withdraw_then_hit", st, 0);

      // Random traffic against the reference model.
      for (int n = 0; n < 250; n++) begin
         int          t  = $urandom_range(0, 3);
         logic [22:0] hi = (t == 3) ? 23'h7FFFFF : 23'(t);
         logic [31:0] a  = {hi, 9'($urandom_range(0, 511))};
         int          op = $urandom_range(0, 9);
         logic [2:0]  f3 [5];
         f3[0] = 3'b000; f3[1] = 3'b001; f3[2] = 3'b010; f3[3] = 3'b100; f3[4] = 3'b101;
         mem_lat = $urandom_range(0, 2);
         if (op < 6)
            acc({1'b1, f3[$urandom_range(0, 4)]}, 3'b000, a, 32'h0, rd, st);
         else
            acc(4'b0000, {1'b1, 2'($urandom_range(0, 2))}, a, $urandom, rd, st);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
